// File: rtl/ro_freq_counter_if.sv
// Wishbone slave bus bundle for the ring-oscillator frequency counter.
interface ro_freq_counter_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: selects one of N_RO oscillators, enables
// it, counts its rising edges over a programmable gate window and reports the
// result over a Wishbone slave port. Supports continuous mode, abort,
// overflow detection and a level interrupt.
module ro_freq_counter #(
  parameter int N_RO       = 16,
  parameter int CNT_W      = 24,
  parameter int GATE_W     = 20,
  parameter int SETTLE_CYC = 16,
  localparam int SEL_W     = (N_RO > 1) ? $clog2(N_RO) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  ro_freq_counter_if.slave     wb,
  input  logic [N_RO-1:0]      ro_in,
  output logic                 ro_start_o,
  output logic [SEL_W-1:0]     mux_sel_o,
  output logic                 irq_o
);

  localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [GATE_W-1:0] GATE_RST = GATE_W'(1000);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_DONE
  } state_t;

  state_t state;

  // Configuration / result registers
  logic              ctrl_cont;
  logic              ctrl_ie;
  logic [SEL_W-1:0]  ctrl_sel;
  logic [GATE_W-1:0] gate_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              ovf_reg;
  logic              done_reg;

  // Measurement datapath
  logic [ST_W-1:0]   settle_cnt;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              ovf_flag;

  // Input synchroniser and edge detect
  logic [N_RO-1:0]   s1, s2, s3;
  logic              ro_edge;

  // Bus decode
  logic              req;
  logic              wr;
  logic [1:0]        addr;
  logic              wr_ctrl, wr_gate, wr_status;
  logic              busy;
  logic              start_req;
  logic              abort_req;
  logic [GATE_W-1:0] gate_load;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign req       = wb.wbs_stb_i & wb.wbs_cyc_i;
  assign wr        = req & wb.wbs_ack_o & wb.wbs_we_i;
  assign addr      = wb.wbs_adr_i[3:2];
  assign wr_ctrl   = wr && (addr == 2'd0);
  assign wr_gate   = wr && (addr == 2'd1);
  assign wr_status = wr && (addr == 2'd3);
  assign busy      = (state != S_IDLE);
  assign abort_req = wr_ctrl & wb.wbs_dat_i[2];
  assign start_req = wr_ctrl & wb.wbs_dat_i[0] & ~wb.wbs_dat_i[2] & ~busy;
  assign gate_load = (gate_reg == '0) ? GATE_W'(1) : gate_reg;
  assign ro_edge   = s2[mux_sel_o] & ~s3[mux_sel_o];

  assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0],
                         wb.wbs_dat_i};

  // Read-data mux for the addressed register
  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: begin
        rdata[1]            = ctrl_cont;
        rdata[3]            = ctrl_ie;
        rdata[8 +: SEL_W]   = ctrl_sel;
      end
      2'd1: rdata[GATE_W-1:0] = gate_reg;
      2'd2: rdata[CNT_W-1:0]  = count_reg;
      default: rdata[2:0]     = {ovf_reg, done_reg, busy};
    endcase
  end

  // Single-cycle Wishbone acknowledge with registered read data
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= req & ~wb.wbs_ack_o;
      wb.wbs_dat_o <= (req & ~wb.wbs_ack_o & ~wb.wbs_we_i) ? rdata : '0;
    end
  end

  // Control and gate-length register writes; SEL/GATE frozen while busy
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ctrl_cont <= 1'b0;
      ctrl_ie   <= 1'b0;
      ctrl_sel  <= '0;
      gate_reg  <= GATE_RST;
    end else begin
      if (wr_ctrl) begin
        ctrl_cont <= wb.wbs_dat_i[1];
        ctrl_ie   <= wb.wbs_dat_i[3];
        if (!busy) ctrl_sel <= wb.wbs_dat_i[8 +: SEL_W];
      end
      if (wr_gate && !busy) gate_reg <= wb.wbs_dat_i[GATE_W-1:0];
    end
  end

  // Two-flop synchroniser plus delay flop for edge detection
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= ro_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Measurement FSM, result registers, sticky DONE and interrupt
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state      <= S_IDLE;
      ro_start_o <= 1'b0;
      mux_sel_o  <= '0;
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_flag   <= 1'b0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      irq_o <= done_reg & ctrl_ie;
      // W1C first so an FSM set in the same cycle overrides it
      if (wr_status && wb.wbs_dat_i[1]) done_reg <= 1'b0;
      if (abort_req) begin
        state      <= S_IDLE;
        ro_start_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_req) begin
              // SEL arrives in the same write as START, so take it from the bus
              mux_sel_o  <= wb.wbs_dat_i[8 +: SEL_W];
              gate_cnt   <= gate_load;
              settle_cnt <= ST_W'(SETTLE_CYC);
              edge_cnt   <= '0;
              ovf_flag   <= 1'b0;
              ro_start_o <= 1'b1;
              state      <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            if (settle_cnt <= ST_W'(1)) state <= S_GATE;
            else settle_cnt <= settle_cnt - ST_W'(1);
          end
          S_GATE: begin
            if (ro_edge) begin
              if (edge_cnt == '1) ovf_flag <= 1'b1;
              else edge_cnt <= edge_cnt + CNT_W'(1);
            end
            if (gate_cnt <= GATE_W'(1)) state <= S_DONE;
            else gate_cnt <= gate_cnt - GATE_W'(1);
          end
          default: begin
            count_reg <= edge_cnt;
            ovf_reg   <= ovf_flag;
            done_reg  <= 1'b1;
            if (ctrl_cont) begin
              edge_cnt <= '0;
              ovf_flag <= 1'b0;
              gate_cnt <= gate_load;
              state    <= S_GATE;
            end else begin
              ro_start_o <= 1'b0;
              state      <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard testbench for ro_freq_counter: two instances (default and
// CNT_W=8), directed register-level stimulus, reads checked by a monitor.
module tb_ro_freq_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ro_freq_counter_if bus0();
  ro_freq_counter_if bus8();

  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_w = '0;
  int          tgt = 0;

  assign bus0.wbs_stb_i = stb && (tgt == 0);
  assign bus0.wbs_cyc_i = cyc && (tgt == 0);
  assign bus0.wbs_we_i  = we;
  assign bus0.wbs_sel_i = 4'hF;
  assign bus0.wbs_adr_i = adr;
  assign bus0.wbs_dat_i = dat_w;
  assign bus8.wbs_stb_i = stb && (tgt == 1);
  assign bus8.wbs_cyc_i = cyc && (tgt == 1);
  assign bus8.wbs_we_i  = we;
  assign bus8.wbs_sel_i = 4'hF;
  assign bus8.wbs_adr_i = adr;
  assign bus8.wbs_dat_i = dat_w;

  logic        ack;
  logic [31:0] rdat;
  assign ack  = (tgt == 0) ? bus0.wbs_ack_o : bus8.wbs_ack_o;
  assign rdat = (tgt == 0) ? bus0.wbs_dat_o : bus8.wbs_dat_o;

  logic [15:0] ro = '0;
  int          half [16];
  int          phase [16];

  logic       ro_start0, irq0, ro_start8, irq8;
  logic [3:0] mux0, mux8;

  ro_freq_counter dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb(bus0.slave), .ro_in(ro),
    .ro_start_o(ro_start0), .mux_sel_o(mux0), .irq_o(irq0)
  );

  ro_freq_counter #(.CNT_W(8)) dut8 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb(bus8.slave), .ro_in(ro),
    .ro_start_o(ro_start8), .mux_sel_o(mux8), .irq_o(irq8)
  );

  // Oscillator model: channel i toggles every half[i] clock cycles
  initial begin
    for (int i = 0; i < 16; i++) begin
      half[i]  = 0;
      phase[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (half[i] != 0) begin
        phase[i]++;
        if (phase[i] >= half[i]) begin
          phase[i] = 0;
          ro[i] = ~ro[i];
        end
      end
    end
  end

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  // Monitor: every read acknowledge is matched against the scoreboard head
  always @(negedge clk) begin
    if (ack && !we) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h with empty scoreboard", rdat);
      end else begin
        mon_e = sb.pop_front();
        if (rdat < mon_e.lo || rdat > mon_e.hi) begin
          n_fail++;
          $display("FAIL %s: got %0d (0x%08h), want %0d..%0d",
                   mon_e.name, rdat, rdat, mon_e.lo, mon_e.hi);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic wb_cycle(input int t, input int a, input logic [31:0] d, input logic w);
    int n;
    @(negedge clk);
    tgt = t; adr = 32'(a) << 2; dat_w = d; we = w; stb = 1'b1; cyc = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    if (!ack) begin
      n_chk++;
      n_fail++;
      $display("FAIL bus_timeout: no ack after %0d cycles, want ack", n);
    end
    @(posedge clk);
    #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input int t, input int a, input logic [31:0] d);
    wb_cycle(t, a, d, 1'b1);
  endtask

  task automatic wb_read(input int t, input int a, input string name,
                         input logic [31:0] lo, input logic [31:0] hi);
    exp_t e;
    e.name = name; e.lo = lo; e.hi = hi;
    sb.push_back(e);
    wb_cycle(t, a, '0, 1'b0);
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return ro_start0;
      1:       return irq0;
      default: return ro_start8;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input int bound, input string name);
    int n = 0;
    while (sig(which) !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sig(which) !== val) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, got %0b want %0b", name, n, sig(which), val);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // 1: reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ro_start", 32'(ro_start0), 0);
    chk("rst_mux_sel", 32'(mux0), 0);
    chk("rst_irq", 32'(irq0), 0);
    chk("rst_ack", 32'(bus0.wbs_ack_o), 0);
    chk("rst_dat", bus0.wbs_dat_o, 0);
    chk("rst8_ro_start", 32'(ro_start8), 0);
    rst_n = 1'b1;
    wb_read(0, 0, "rst_ctrl", 0, 0);
    wb_read(0, 1, "rst_gate", 1000, 1000);
    wb_read(0, 2, "rst_count", 0, 0);
    wb_read(0, 3, "rst_status", 0, 0);
    wb_read(1, 1, "rst8_gate", 1000, 1000);

    // 2: single measurement, period-8 input on channel 3, GATE=100
    half[3] = 4;
    wb_write(0, 1, 100);
    wb_write(0, 0, 32'h301);
    n = 0;
    @(negedge clk);
    while (ro_start0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("t2_ro_start_len", 32'(n), 117);
    chk("t2_mux_sel", 32'(mux0), 3);
    wb_read(0, 2, "t2_count", 12, 13);
    wb_read(0, 3, "t2_status", 2, 2);
    chk("t2_irq_ie0", 32'(irq0), 0);

    // 3: saturation on the 8-bit instance
    half[3] = 2;
    wb_write(1, 1, 4000);
    wb_write(1, 0, 32'h301);
    wait_sig(2, 1'b0, 5000, "t3_wait_done");
    wb_read(1, 2, "t3_count_sat", 255, 255);
    wb_read(1, 3, "t3_status_ovf", 6, 6);

    // 4: continuous mode with interrupt, period-10 input, GATE=50
    half[3] = 5;
    wb_write(0, 3, 32'h2);
    repeat (2) @(negedge clk);
    chk("t4_irq_pre", 32'(irq0), 0);
    wb_write(0, 1, 50);
    wb_write(0, 0, 32'h30B);
    wait_sig(1, 1'b1, 300, "t4_irq_w1");
    wb_read(0, 2, "t4_count_w1", 5, 5);
    chk("t4_irq_w1_high", 32'(irq0), 1);
    wb_write(0, 3, 32'h2);
    wb_read(0, 3, "t4_status_cleared", 1, 1);
    chk("t4_irq_cleared", 32'(irq0), 0);
    wait_sig(1, 1'b1, 300, "t4_irq_w2");
    wb_read(0, 2, "t4_count_w2", 5, 5);
    wb_write(0, 3, 32'h2);
    wb_write(0, 0, 32'h8);
    wait_sig(0, 1'b0, 300, "t4_stop");
    wb_read(0, 3, "t4_status_idle", 2, 2);
    wb_read(0, 2, "t4_count_w3", 5, 5);
    wb_read(0, 0, "t4_ctrl", 32'h308, 32'h308);
    chk("t4_irq_final", 32'(irq0), 1);
    repeat (80) @(negedge clk);
    chk("t4_no_restart", 32'(ro_start0), 0);

    // 5: abort mid-gate, SEL write while busy ignored
    wb_write(0, 1, 200);
    wb_write(0, 0, 32'h301);
    repeat (40) @(negedge clk);
    wb_write(0, 0, 32'h700);
    chk("t5_sel_locked", 32'(mux0), 3);
    chk("t5_busy_before_abort", 32'(ro_start0), 1);
    wb_write(0, 0, 32'h4);
    @(negedge clk);
    chk("t5_abort_ro_start", 32'(ro_start0), 0);
    wb_read(0, 3, "t5_status", 2, 2);
    wb_read(0, 2, "t5_count_kept", 5, 5);
    wb_read(0, 0, "t5_ctrl", 32'h300, 32'h300);

    // 6: reset during SETTLE
    wb_write(0, 0, 32'h501);
    repeat (5) @(negedge clk);
    chk("t6_settling", 32'(ro_start0), 1);
    chk("t6_mux_sel", 32'(mux0), 5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_ro_start", 32'(ro_start0), 0);
    chk("t6_rst_mux_sel", 32'(mux0), 0);
    chk("t6_rst_irq", 32'(irq0), 0);
    rst_n = 1'b1;
    wb_read(0, 0, "t6_ctrl", 0, 0);
    wb_read(0, 1, "t6_gate", 1000, 1000);
    wb_read(0, 2, "t6_count", 0, 0);
    wb_read(0, 3, "t6_status", 0, 0);

    repeat (5) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_freq_counter.md
# ro_freq_counter

Parametrised ring-oscillator frequency counter for the user project area. It selects one of `N_RO` oscillator outputs and enables that oscillator. It counts the oscillator's rising edges over a programmable gate window of clock cycles and returns the result over the Wishbone slave port. It generalises the fixed 16:1 output mux with on-chip measurement, a continuous mode, overflow detection and an interrupt.

## Interface
Parameters:
- `N_RO`, 16: number of oscillator inputs. Select width `SEL_W = $clog2(N_RO)`.
- `CNT_W`, 24: edge-counter width, max 32.
- `GATE_W`, 20: gate-length register width.
- `SETTLE_CYC`, 16: cycles between oscillator enable and gate opening.

Ports:
- `wb_clk_i` input 1: single clock for all logic.
- `wb_rst_ni` input 1: reset, synchronous, active-low.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` input 1 each: Wishbone strobe, cycle and write-enable.
- `wbs_adr_i` input 32: only bits [3:2] are decoded.
- `wbs_dat_i` input 32: write data. Writes are full-word; `wbs_sel_i` input 4 is ignored.
- `wbs_ack_o` output 1: single-cycle acknowledge.
- `wbs_dat_o` output 32: read data.
- `ro_in` input `N_RO`: oscillator outputs, asynchronous to `wb_clk_i`. Each is pre-divided so its frequency is ≤ f(wb_clk_i)/4.
- `ro_start_o` output 1: oscillator enable, driven to the ring oscillators' start pins.
- `mux_sel_o` output `SEL_W`: the latched active select.
- `irq_o` output 1: level interrupt.

## Operation
Register map (`wbs_adr_i[3:2]`):
- 0 CTRL (RW):
  - bit0 START: write-1, self-clearing, reads 0.
  - bit1 CONT: continuous mode.
  - bit2 ABORT: write-1, self-clearing.
  - bit3 IE: interrupt enable.
  - bits[8+SEL_W-1:8] SEL.
  - Reset 0.
- 1 GATE (RW): gate length in cycles. Reset 1000. Value 0 is treated as 1.
- 2 COUNT (RO): last completed result, zero-extended. Reset 0.
- 3 STATUS:
  - bit0 BUSY (RO).
  - bit1 DONE: sticky, write-1-to-clear.
  - bit2 OVF (RO): overflow flag of the last result.
  - Reset 0.

Register write rules:
- Writes to SEL or GATE while BUSY are ignored.
- START while BUSY is ignored.

Input path: every `ro_in` bit passes through a 2-flop synchroniser and a delay flop. An edge is `s2 & ~s3` on the selected channel.

FSM states:
- IDLE: `ro_start_o`=0. START latches SEL into `mux_sel_o` and GATE into the gate counter, then goes to SETTLE.
- SETTLE: `ro_start_o`=1. Waits `SETTLE_CYC` cycles with the edge counter cleared, then goes to GATE.
- GATE: counts edges for exactly GATE cycles. The counter saturates at all-ones and sets an internal overflow flag. Goes to DONE.
- DONE (1 cycle):
  - COUNT ← counter; OVF ← overflow flag; DONE ← 1.
  - If CONT=1, go to GATE with the counter and overflow flag cleared; the oscillator stays enabled and the select stays latched.
  - Otherwise go to IDLE.
- ABORT in any state: IDLE next cycle. COUNT, OVF and DONE are unchanged.
- Clearing CONT during continuous operation: the current window completes and the FSM then returns to IDLE.
- `irq_o` = DONE & IE. This output is registered.
- If DONE is set by the FSM and W1C-cleared in the same cycle, the set wins.

Wishbone:
- `wbs_ack_o` is asserted one cycle after `stb & cyc` while ack is low, for exactly one cycle.
- The write takes effect on the ack cycle.
- Read data is valid on the ack cycle; otherwise `wbs_dat_o`=0.

## Timing
- All outputs reset to 0 on the clock edge where `wb_rst_ni`=0. GATE resets to 1000.
- Reset in any state returns the FSM to IDLE and deasserts `ro_start_o` on the next edge.
- START acked at cycle T:
  - SETTLE runs T+1 .. T+SETTLE_CYC, with `ro_start_o`=1 from T+1.
  - GATE runs the next GATE cycles.
  - COUNT, DONE and OVF update at DONE. `irq_o` rises one cycle later.
- Edge-to-count latency is 3 cycles. Edges still in the synchroniser when the window closes belong to the next window in CONT mode; otherwise they are discarded.
- In CONT mode, successive windows are separated by exactly one DONE cycle; no edges are counted in that cycle.

## Test plan
- 1: Reset. Expect every register and output at its reset value and `wbs_dat_o`=0.
- 2: SEL=3, GATE=100, `ro_in[3]` toggling with period 8 cycles, START. Expect COUNT=12 or 13, DONE=1, OVF=0, `mux_sel_o`=3, and `ro_start_o` high for 16+100+1 cycles.
- 3: CNT_W=8, GATE=4000, period-4 input. Expect COUNT=255 and OVF=1.
- 4: CONT=1, IE=1, GATE=50, period-10 input. Expect COUNT=5 each window, `irq_o` rising after the first window, and W1C clearing DONE between windows. Clear CONT: expect IDLE after the current window.
- 5: ABORT mid-GATE. Expect IDLE next cycle, `ro_start_o`=0 and COUNT unchanged. Write SEL=7 while BUSY: expect `mux_sel_o` unchanged.
- 6: Assert `wb_rst_ni` low mid-SETTLE. Expect outputs at reset values on the next edge and the FSM in IDLE.
